// File: rtl/series_arbiter_if.sv
// Requester-side and engine-side signals of the series_arbiter, bundled as one interface.
// slave is the arbiter's view; master is the view of the clients plus the engine.
interface series_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned XW   = 16,
  parameter int unsigned RW   = 18
);
  logic [NREQ-1:0]    reqValid;
  logic [NREQ*XW-1:0] reqX;
  logic [NREQ-1:0]    reqFunc;
  logic [NREQ-1:0]    reqReady;
  logic [NREQ-1:0]    rspValid;
  logic [NREQ-1:0]    rspReady;
  logic [RW-1:0]      rspData;
  logic               rspErr;
  logic               engStart;
  logic [XW-1:0]      engX;
  logic               engFunc;
  logic [RW-1:0]      engR;
  logic               engDone;
  logic               busy;

  modport master (
    output reqValid, reqX, reqFunc, rspReady, engR, engDone,
    input  reqReady, rspValid, rspData, rspErr, engStart, engX, engFunc, busy
  );

  modport slave (
    input  reqValid, reqX, reqFunc, rspReady, engR, engDone,
    output reqReady, rspValid, rspData, rspErr, engStart, engX, engFunc, busy
  );
endinterface

// File: rtl/series_arbiter.sv
// Round-robin scheduler sharing one sine/cosine series engine among NREQ requesters.
// Define SERIES_ARB_TIMEOUT_EN to add an engine watchdog that returns rspErr after TIMEOUT cycles.
module series_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned XW      = 16,
  parameter int unsigned RW      = 18,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  series_arbiter_if.slave   bus
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [XW-1:0]   eng_x_q, eng_x_d;
  logic            eng_func_q, eng_func_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            armed_q, armed_d;

  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic            eng_start;
  logic            win_any;
  logic [IW-1:0]   win_idx;
  int              cand;

`ifdef SERIES_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Round-robin search from ptr+1; scanning downward lets the nearest candidate win last.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = int'(NREQ); k > 0; k--) begin
      cand = (int'(ptr_q) + k) % int'(NREQ);
      if (bus.reqValid[cand]) begin
        win_any = 1'b1;
        win_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    eng_x_d    = eng_x_q;
    eng_func_d = eng_func_q;
    rsp_data_d = rsp_data_q;
    armed_d    = armed_q;
    req_ready  = '0;
    rsp_valid  = '0;
    eng_start  = 1'b0;
`ifdef SERIES_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      StIdle: begin
        // The winner always has reqValid high, so a grant is also the handshake.
        if (win_any) begin
          req_ready[win_idx] = 1'b1;
          gnt_d              = win_idx;
          ptr_d              = win_idx;
          eng_x_d            = bus.reqX[win_idx*XW +: XW];
          eng_func_d         = bus.reqFunc[win_idx];
          state_d            = StIssue;
        end
      end

      StIssue: begin
        eng_start = 1'b1;
        armed_d   = 1'b0;
`ifdef SERIES_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
        state_d   = StWait;
      end

      StWait: begin
        // armed_q is low in the first WAIT cycle so a done left over from the last op is ignored.
        armed_d = 1'b1;
        if (armed_q && bus.engDone) begin
          rsp_data_d = bus.engR;
          state_d    = StResp;
        end
`ifdef SERIES_ARB_TIMEOUT_EN
        else if (cnt_q == CntLast) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      StResp: begin
        rsp_valid[gnt_q] = 1'b1;
        if (bus.rspReady[gnt_q]) begin
`ifdef SERIES_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= IW'(NREQ - 1);
      gnt_q      <= '0;
      eng_x_q    <= '0;
      eng_func_q <= 1'b0;
      rsp_data_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      eng_x_q    <= eng_x_d;
      eng_func_q <= eng_func_d;
      rsp_data_q <= rsp_data_d;
      armed_q    <= armed_d;
    end
  end

`ifdef SERIES_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.rspErr = err_q;
`else
  assign bus.rspErr = 1'b0;
`endif

  assign bus.reqReady = req_ready;
  assign bus.rspValid = rsp_valid;
  assign bus.rspData  = rsp_data_q;
  assign bus.engStart = eng_start;
  assign bus.engX     = eng_x_q;
  assign bus.engFunc  = eng_func_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: doc/series_arbiter.md
# series_arbiter

Round-robin scheduler that shares a single Maclaurin series engine (the `start`/`xBus`/`rBus`/`done` sine/cosine datapath) among `NREQ` requesters. It accepts one argument per requester through a valid/ready handshake and sequences the engine's start pulse. It captures the 18-bit result and returns it to the originating requester through a per-requester valid/ready response. The block sits between the application-side clients and the single engine instance in the top level.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `XW`, 16: argument width; matches engine `xBus`.
- `RW`, 18: result width; matches engine `rBus`.
- `TIMEOUT`, 255: engine watchdog limit in cycles; used only with `SERIES_ARB_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `reqValid`  in  NREQ  requester i presents an argument.
- `reqX`  in  NREQ*XW  argument for requester i in bits [i*XW +: XW].
- `reqFunc`  in  NREQ  function select: 0 = sine, 1 = cosine.
- `reqReady`  out  NREQ  one-hot; the argument is accepted on `reqValid[i] & reqReady[i]`.
- `rspValid`  out  NREQ  one-hot; the result for requester i is available.
- `rspReady`  in  NREQ  requester i consumes the result.
- `rspData`  out  RW  result; valid while any `rspValid` bit is high.
- `rspErr`  out  1  timeout flag qualifying `rspData` (tied 0 without the macro).
- `engStart`  out  1  one-cycle start pulse to the engine.
- `engX`  out  XW  latched argument to the engine.
- `engFunc`  out  1  latched function select to the engine.
- `engR`  in  RW  engine result.
- `engDone`  in  1  engine completion.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `reqValid` is high, pick the winner by round-robin. The search starts at `ptr+1` modulo NREQ.
  - Drive `reqReady` one-hot for the winner, combinationally in the same cycle.
  - On the handshake: latch `reqX`/`reqFunc` into `engX`/`engFunc`, store the winner index in `gnt`, set `ptr <= gnt`, and go to ISSUE.
- **ISSUE**
  - `engStart = 1` for exactly one cycle, then go to WAIT.
  - `engX` and `engFunc` are stable from ISSUE through the end of WAIT.
- **WAIT**
  - `engDone` is ignored in the first WAIT cycle (masks a stale done from the previous operation).
  - From the second WAIT cycle on, `engDone == 1` captures `engR` into `rspData` and moves to RESP.
- **RESP**
  - `rspValid[gnt] = 1`; hold `rspData` stable until `rspReady[gnt]`, then go to IDLE.
  - `rspReady` bits for other indices are ignored.
- Fairness: a requester that holds `reqValid` is granted within NREQ operations.
- Back-to-back: the IDLE cycle after RESP can accept the next request immediately.
- Reset values:
  - State = IDLE, `ptr = NREQ-1` (requester 0 has first priority), `gnt = 0`.
  - `reqReady = 0`, `rspValid = 0`, `rspData = 0`, `rspErr = 0`.
  - `engStart = 0`, `engX = 0`, `engFunc = 0`, `busy = 0`.
- Reset mid-operation returns everything to the reset values at once. No response is produced, and the engine is expected to be reset by the same `rst`.
- `reqValid` withdrawn in IDLE before the handshake: no grant, `ptr` unchanged.

## Timing
- Request handshake cycle T (IDLE) → `engStart` high at T+1 → WAIT from T+2.
- `engDone` is accepted from T+3 onward.
- `engDone` seen at cycle D → `rspValid` high at D+1.
- Minimum request-to-response latency is 3 cycles plus the engine latency.
- Overhead per operation: 4 cycles beyond the engine latency with `rspReady` held high.
- Only one operation is in flight at a time; `reqReady` is 0 outside IDLE.

## Configuration
- `SERIES_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in WAIT.
  - If `engDone` has not arrived after `TIMEOUT` WAIT cycles, go to RESP with `rspData = 0` and `rspErr = 1`.
  - `rspErr` clears on leaving RESP.
- Macro not defined:
  - No counter is built; WAIT lasts indefinitely until `engDone`.
  - `rspErr` is constant 0.

## Test plan
- Reset, requester 0 only, `reqX = 16'h1000`, `reqFunc = 0`, engine model returns `18'h01000` after 20 cycles → `engStart` is a single pulse with `engX = 16'h1000`; `rspValid = 4'b0001` with `rspData = 18'h01000`; `busy` drops after `rspReady`.
- All four requesters valid continuously, 8 operations → grant order 0,1,2,3,0,1,2,3; every `rspValid` matches its grant.
- Requester 2 with `reqFunc = 1`, `rspReady` held low for 10 cycles → `engFunc = 1`; `rspData` and `rspValid = 4'b0100` stable for all 10 cycles; no new `reqReady` during that time.
- Engine `engDone` stuck high from the previous operation → the first WAIT cycle is masked; the response uses the new `engR` sampled no earlier than T+3.
- `rst` asserted low during WAIT → all outputs return to reset values asynchronously; after release, requester 0 is granted first.
- With `SERIES_ARB_TIMEOUT_EN` and `TIMEOUT = 255`, engine never asserts done → `rspValid` after 255 WAIT cycles, with `rspErr = 1` and `rspData = 0`.
